// File: rtl/e203_ifu_realign.sv
// e203_ifu_realign: splits a stream of word-aligned 32-bit fetch words into
// RV32/RVC instructions, one per cycle, with zero input-to-output latency.
// Halfwords are classified as the start of a 32-bit instruction when
// bits[1:0]==2'b11, otherwise as a 16-bit instruction.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_valid/i_ready     fetch-word handshake (i_word, i_pc, i_err)
//   flush_req           one-cycle flush; flush_hwofs skips the low halfword
//                       of the next word (redirect target bit 1)
//   o_valid/o_ready     instruction handshake (o_instr, o_pc, o_rv32, o_buserr)
module e203_ifu_realign #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [31:0]     i_word,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_err,
  input  logic            flush_req,
  input  logic            flush_hwofs,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [31:0]     o_instr,
  output logic [PC_W-1:0] o_pc,
  output logic            o_rv32,
  output logic            o_buserr
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HALF,
    ST_SKIP
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     hb_q, hb_d;
  logic [PC_W-1:0] hpc_q, hpc_d;
  logic            hb_err_q, hb_err_d;

  // Address bits [1:0] of the fetch word carry no information.
  logic unused_pc_lo;
  assign unused_pc_lo = ^i_pc[1:0];

  // The word address is 4-aligned, so +2 only sets bit 1 (wraps naturally).
  logic [PC_W-1:0] pc_lo, pc_hi;
  assign pc_lo = {i_pc[PC_W-1:2], 2'b00};
  assign pc_hi = {i_pc[PC_W-1:2], 2'b10};

  logic lo_is32, hi_is32, hb_is32;
  assign lo_is32 = (i_word[1:0] == 2'b11);
  assign hi_is32 = (i_word[17:16] == 2'b11);
  assign hb_is32 = (hb_q[1:0] == 2'b11);

  logic in_fire;
  assign in_fire = i_valid && o_ready;

  always_comb begin
    state_d  = state_q;
    hb_d     = hb_q;
    hpc_d    = hpc_q;
    hb_err_d = hb_err_q;
    o_valid  = 1'b0;
    i_ready  = 1'b0;
    o_instr  = '0;
    o_pc     = '0;
    o_buserr = 1'b0;

    if (rst) begin
      // Outputs stay idle; the registers are cleared in the state register.
    end else if (flush_req) begin
      i_ready  = 1'b1;
      state_d  = flush_hwofs ? ST_SKIP : ST_EMPTY;
      hb_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          o_valid  = i_valid;
          o_pc     = pc_lo;
          o_buserr = i_err;
          i_ready  = o_ready;
          if (lo_is32) begin
            o_instr = i_word;
          end else begin
            o_instr = {16'h0, i_word[15:0]};
            if (in_fire) begin
              hb_d     = i_word[31:16];
              hpc_d    = pc_hi;
              hb_err_d = i_err;
              state_d  = ST_HALF;
            end
          end
        end

        ST_SKIP: begin
          if (hi_is32) begin
            // Upper halfword starts a 32-bit instruction: park it, emit nothing.
            i_ready = 1'b1;
            if (i_valid) begin
              hb_d     = i_word[31:16];
              hpc_d    = pc_hi;
              hb_err_d = i_err;
              state_d  = ST_HALF;
            end
          end else begin
            o_valid  = i_valid;
            o_instr  = {16'h0, i_word[31:16]};
            o_pc     = pc_hi;
            o_buserr = i_err;
            i_ready  = o_ready;
            if (in_fire) begin
              state_d = ST_EMPTY;
            end
          end
        end

        ST_HALF: begin
          o_pc = hpc_q;
          if (hb_is32) begin
            o_valid  = i_valid;
            o_instr  = {i_word[15:0], hb_q};
            o_buserr = hb_err_q | i_err;
            i_ready  = o_ready;
            if (in_fire) begin
              hb_d     = i_word[31:16];
              hpc_d    = pc_hi;
              hb_err_d = i_err;
            end
          end else begin
            o_valid  = 1'b1;
            o_instr  = {16'h0, hb_q};
            o_buserr = hb_err_q;
            if (o_ready) begin
              state_d = ST_EMPTY;
            end
          end
        end

        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  assign o_rv32 = (o_instr[1:0] == 2'b11);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      hb_q     <= '0;
      hpc_q    <= '0;
      hb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hb_q     <= hb_d;
      hpc_q    <= hpc_d;
      hb_err_q <= hb_err_d;
    end
  end

endmodule

// File: tb/tb_e203_ifu_realign.sv
// Testbench for e203_ifu_realign: directed vectors with literal expectations,
// plus a halfword-queue reference model checked every cycle.
module tb_e203_ifu_realign;

  localparam int PC_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [31:0] i_word = '0;
  logic [31:0] i_pc = '0;
  logic        i_err = 1'b0;
  logic        flush_req = 1'b0;
  logic        flush_hwofs = 1'b0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_rv32;
  logic        o_buserr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  e203_ifu_realign #(.PC_W(PC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_word      (i_word),
    .i_pc        (i_pc),
    .i_err       (i_err),
    .flush_req   (flush_req),
    .flush_hwofs (flush_hwofs),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_instr     (o_instr),
    .o_pc        (o_pc),
    .o_rv32      (o_rv32),
    .o_buserr    (o_buserr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of pending halfwords (value, address, error).
  typedef struct packed {
    logic [15:0] hw;
    logic [31:0] pc;
    logic        err;
  } hw_t;

  hw_t  pend[$];
  hw_t  npend[$];
  hw_t  avail[$];
  logic skip = 1'b0;
  logic nskip;
  logic e_ov, e_ir, chk_ir, e_err;
  logic [31:0] e_instr, e_pc;

  task automatic model_eval;
    hw_t t;
    int  need;
    int  np;
    bit  uses;
    npend   = pend;
    nskip   = skip;
    e_ov    = 1'b0;
    e_ir    = 1'b0;
    chk_ir  = 1'b0;
    e_instr = '0;
    e_pc    = '0;
    e_err   = 1'b0;
    if (rst) begin
      npend  = {};
      nskip  = 1'b0;
      chk_ir = 1'b1;
    end else if (flush_req) begin
      npend  = {};
      nskip  = flush_hwofs;
      e_ir   = 1'b1;
      chk_ir = 1'b1;
    end else begin
      avail = pend;
      np    = pend.size();
      if (i_valid) begin
        if (!skip) begin
          t.hw  = i_word[15:0];
          t.pc  = {i_pc[31:2], 2'b00};
          t.err = i_err;
          avail.push_back(t);
        end
        t.hw  = i_word[31:16];
        t.pc  = {i_pc[31:2], 2'b00} + 32'd2;
        t.err = i_err;
        avail.push_back(t);
      end
      chk_ir = i_valid;
      need = (avail.size() > 0 && avail[0].hw[1:0] == 2'b11) ? 2 : 1;
      if (avail.size() >= need) begin
        e_ov = 1'b1;
        e_pc = avail[0].pc;
        if (need == 2) begin
          e_instr = {avail[1].hw, avail[0].hw};
          e_err   = avail[0].err | avail[1].err;
        end else begin
          e_instr = {16'h0, avail[0].hw};
          e_err   = avail[0].err;
        end
        uses = (need > np);
        e_ir = uses ? o_ready : 1'b0;
        if (o_ready) begin
          npend = {};
          if (uses) begin
            for (int i = need; i < avail.size(); i++) npend.push_back(avail[i]);
            nskip = 1'b0;
          end else begin
            for (int i = need; i < np; i++) npend.push_back(pend[i]);
          end
        end
      end else if (i_valid) begin
        e_ir  = 1'b1;
        npend = avail;
        nskip = 1'b0;
      end
    end
  endtask

  // Compare process: evaluate on the falling edge, commit on the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      model_eval();
      chk("m_o_valid", 32'(o_valid), 32'(e_ov));
      if (chk_ir) chk("m_i_ready", 32'(i_ready), 32'(e_ir));
      if (e_ov && o_valid) begin
        chk("m_o_instr", o_instr, e_instr);
        chk("m_o_pc", o_pc, e_pc);
        chk("m_o_buserr", 32'(o_buserr), 32'(e_err));
        chk("m_o_rv32", 32'(o_rv32), 32'(e_instr[1:0] == 2'b11));
      end
      @(posedge clk);
      pend = npend;
      skip = nskip;
    end
  end

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic e, input logic ordy, input logic fl, input logic fh);
    i_valid     = v;
    i_word      = w;
    i_pc        = pc;
    i_err       = e;
    o_ready     = ordy;
    flush_req   = fl;
    flush_hwofs = fh;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] pc;
    logic        fire;
    int          k;
    int          cyc;

    @(posedge clk);
    #1;
    // Reset dominates a simultaneous flush.
    drive(1, 32'h00A00093, 32'h0, 0, 1, 1, 1);
    chk("rst_o_valid", 32'(o_valid), 0);
    chk("rst_i_ready", 32'(i_ready), 0);
    tick;
    rst = 1'b0;

    drive(1, 32'h00A00093, 32'h80000000, 0, 1, 0, 0);
    chk("rv32_valid", 32'(o_valid), 1);
    chk("rv32_instr", o_instr, 32'h00A00093);
    chk("rv32_pc", o_pc, 32'h80000000);
    chk("rv32_flag", 32'(o_rv32), 1);
    chk("rv32_iready", 32'(i_ready), 1);
    tick;

    drive(1, 32'h45014481, 32'h100, 0, 1, 0, 0);
    chk("rvc1_instr", o_instr, 32'h00004481);
    chk("rvc1_pc", o_pc, 32'h100);
    chk("rvc1_iready", 32'(i_ready), 1);
    tick;
    drive(1, 32'h00930001, 32'h200, 0, 1, 0, 0);
    chk("rvc2_valid", 32'(o_valid), 1);
    chk("rvc2_instr", o_instr, 32'h00004501);
    chk("rvc2_pc", o_pc, 32'h102);
    chk("rvc2_iready", 32'(i_ready), 0);
    chk("rvc2_rv32", 32'(o_rv32), 0);
    tick;

    // Straddle, without and then with a bus error on the first word.
    for (int r = 0; r < 2; r++) begin
      drive(1, 32'h00930001, 32'h200, logic'(r), 1, 0, 0);
      chk("str_a_instr", o_instr, 32'h00000001);
      chk("str_a_pc", o_pc, 32'h200);
      tick;
      drive(1, 32'h12340A00, 32'h204, 0, 1, 0, 0);
      chk("str_b_instr", o_instr, 32'h0A000093);
      chk("str_b_pc", o_pc, 32'h202);
      chk("str_b_rv32", 32'(o_rv32), 1);
      chk("str_b_buserr", 32'(o_buserr), 32'(r));
      tick;
      drive(0, 32'h0, 32'h0, 0, 1, 0, 0);
      chk("str_c_instr", o_instr, 32'h00001234);
      chk("str_c_pc", o_pc, 32'h206);
      chk("str_c_iready", 32'(i_ready), 0);
      chk("str_c_buserr", 32'(o_buserr), 0);
      tick;
    end

    // Backpressure while a 32-bit instruction straddles.
    drive(1, 32'h00930001, 32'h400, 0, 1, 0, 0);
    tick;
    for (int r = 0; r < 3; r++) begin
      drive(1, 32'h12340A00, 32'h404, 0, 0, 0, 0);
      chk("hold_valid", 32'(o_valid), 1);
      chk("hold_instr", o_instr, 32'h0A000093);
      chk("hold_pc", o_pc, 32'h402);
      chk("hold_iready", 32'(i_ready), 0);
      tick;
    end
    drive(1, 32'h12340A00, 32'h404, 0, 1, 0, 0);
    chk("rel_instr", o_instr, 32'h0A000093);
    chk("rel_iready", 32'(i_ready), 1);
    tick;
    drive(1, 32'h00A00093, 32'h408, 0, 1, 0, 0);
    chk("rel_next_instr", o_instr, 32'h00001234);
    chk("rel_next_pc", o_pc, 32'h406);
    chk("rel_next_iready", 32'(i_ready), 0);
    tick;
    drive(1, 32'h00A00093, 32'h408, 0, 1, 0, 0);
    chk("rel_after_instr", o_instr, 32'h00A00093);
    tick;

    // Flush with halfword offset from HALF.
    drive(1, 32'h00930001, 32'h500, 0, 1, 0, 0);
    tick;
    drive(1, 32'h12340A00, 32'h504, 0, 1, 1, 1);
    chk("flush_valid", 32'(o_valid), 0);
    chk("flush_iready", 32'(i_ready), 1);
    tick;
    drive(1, 32'h4501FFFF, 32'h300, 0, 1, 0, 0);
    chk("skip_valid", 32'(o_valid), 1);
    chk("skip_instr", o_instr, 32'h00004501);
    chk("skip_pc", o_pc, 32'h302);
    tick;

    // Skip landing on the start of a 32-bit instruction.
    drive(0, 32'h0, 32'h0, 0, 1, 1, 1);
    tick;
    drive(1, 32'h00930001, 32'h700, 1, 1, 0, 0);
    chk("skip32_valid", 32'(o_valid), 0);
    chk("skip32_iready", 32'(i_ready), 1);
    tick;
    drive(1, 32'h12340A00, 32'h704, 0, 1, 0, 0);
    chk("skip32_instr", o_instr, 32'h0A000093);
    chk("skip32_pc", o_pc, 32'h702);
    chk("skip32_buserr", 32'(o_buserr), 1);
    tick;
    drive(0, 32'h0, 32'h0, 0, 1, 0, 0);
    chk("skip32_tail_pc", o_pc, 32'h706);
    tick;

    // Address wrap, with non-zero low address bits ignored.
    drive(1, 32'h00930001, 32'hFFFFFFFE, 0, 1, 0, 0);
    chk("wrap_a_pc", o_pc, 32'hFFFFFFFC);
    tick;
    drive(1, 32'h12340A00, 32'h0, 0, 1, 0, 0);
    chk("wrap_b_instr", o_instr, 32'h0A000093);
    chk("wrap_b_pc", o_pc, 32'hFFFFFFFE);
    tick;
    drive(0, 32'h0, 32'h0, 0, 1, 0, 0);
    chk("wrap_c_pc", o_pc, 32'h2);
    tick;

    // Reset in the middle of a straddle.
    drive(1, 32'h00930001, 32'h800, 0, 1, 0, 0);
    tick;
    rst = 1'b1;
    drive(1, 32'h12340A00, 32'h804, 0, 1, 1, 0);
    chk("rst_half_valid", 32'(o_valid), 0);
    chk("rst_half_iready", 32'(i_ready), 0);
    tick;
    rst = 1'b0;
    drive(1, 32'h00A00093, 32'h900, 0, 1, 0, 0);
    chk("post_rst_instr", o_instr, 32'h00A00093);
    chk("post_rst_pc", o_pc, 32'h900);
    tick;

    // Pseudo-random traffic checked by the model.
    w   = $urandom;
    pc  = 32'h1000;
    k   = 0;
    cyc = 0;
    while (k < 60 && cyc < 1000) begin
      drive($urandom_range(0, 3) != 0, w, pc, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1);
      fire = i_valid && i_ready;
      tick;
      cyc++;
      if (fire) begin
        k++;
        w  = $urandom;
        pc = pc + 32'd4;
      end
    end
    if (k < 60) chk("tail_progress", k, 60);

    repeat (4) begin
      drive(0, 32'h0, 32'h0, 0, 1, 0, 0);
      tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e203_ifu_realign.md
E203_IFU_REALIGN -- requirements
Module: e203_ifu_realign

Interface
REQ-001 SHALL have parameter PC_W, default 32, PC width in bits.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_valid input 1 and i_ready output 1: fetch-word handshake, transfer when both high.
REQ-005 SHALL have port i_word  input  32  word-aligned fetch data.
REQ-006 SHALL have port i_pc  input  PC_W  address of i_word; bits [1:0] ignored and treated as 00.
REQ-007 SHALL have port i_err  input  1  bus error on i_word.
REQ-008 SHALL have port flush_req  input  1  one-cycle pipeline flush.
REQ-009 SHALL have port flush_hwofs  input  1  redirect target bit1; when set, skip the low halfword of the next word.
REQ-010 SHALL have ports o_valid output 1 and o_ready input 1: instruction handshake towards the mini-decoder/IR.
REQ-011 SHALL have port o_instr  output  32  instruction; 16-bit instructions zero-extended to {16'h0,hw}.
REQ-012 SHALL have ports o_pc output PC_W (instruction address) and o_rv32 output 1 (o_instr[1:0]==2'b11).
REQ-013 SHALL have port o_buserr  output  1  bus error on any contributing halfword.

Function
REQ-014 SHALL classify a halfword as 32-bit-start iff bits[1:0]==2'b11, else 16-bit.
REQ-015 SHALL hold state EMPTY, HALF or SKIP, plus halfword buffer hb, hpc and hb_err.
REQ-016 EMPTY, low hw 32-bit: o_valid=i_valid, o_instr=i_word, o_pc=i_pc, i_ready=o_ready; state unchanged.
REQ-017 EMPTY, low hw 16-bit: o_valid=i_valid, o_instr={16'h0,i_word[15:0]}, o_pc=i_pc, i_ready=o_ready; on transfer hb<=i_word[31:16], hpc<=i_pc+2, hb_err<=i_err, go HALF.
REQ-018 SKIP, upper hw 16-bit: o_valid=i_valid, o_instr={16'h0,i_word[31:16]}, o_pc=i_pc+2, i_ready=o_ready; on transfer go EMPTY.
REQ-019 SKIP, upper hw 32-bit: o_valid=0, i_ready=1; on i_valid capture hb/hpc=i_pc+2/hb_err, go HALF.
REQ-020 HALF, hb 16-bit: o_valid=1, o_instr={16'h0,hb}, o_pc=hpc, o_buserr=hb_err, i_ready=0; on o_ready go EMPTY.
REQ-021 HALF, hb 32-bit: o_valid=i_valid, o_instr={i_word[15:0],hb}, o_pc=hpc, o_buserr=hb_err|i_err, i_ready=o_ready; on transfer reload hb=i_word[31:16], hpc=i_pc+2, hb_err=i_err, stay HALF.
REQ-022 SHALL otherwise drive o_buserr=i_err whenever i_word contributes to o_instr.
REQ-023 SHALL compute PC+2 modulo 2^PC_W (wrap, no carry-out).
REQ-024 With o_valid=1 and o_ready=0, o_instr/o_pc/o_buserr and state SHALL stay stable.
REQ-025 flush_req SHALL have priority over everything: same cycle o_valid=0, i_ready=1 (in-flight word dropped); next state SKIP if flush_hwofs else EMPTY; hb_err cleared.
REQ-026 Latency SHALL be zero cycles input-to-output; throughput one instruction per cycle.

Reset
REQ-027 While rst=1: o_valid=0, i_ready=0; next state EMPTY, hb=0, hpc=0, hb_err=0.
REQ-028 Reset SHALL override flush_req and any in-progress HALF/SKIP state.

Verification
REQ-029 After reset, word 0x00A00093 with pc 0x80000000 and o_ready=1 -> same cycle o_valid=1, o_instr=0x00A00093, o_pc=0x80000000, o_rv32=1, i_ready=1.
REQ-030 Word 0x45014481 with pc 0x100 -> cycle 1: o_instr=0x00004481, pc 0x100, i_ready=1. Cycle 2: o_instr=0x00004501, pc 0x102, i_ready=0, o_rv32=0.
REQ-031 Straddle: 0x00930001@0x200 then 0x12340A00@0x204 -> 0x00000001@0x200, then 0x0A000093@0x202 (o_rv32=1), then 0x00001234@0x206 with i_ready=0.
REQ-032 Hold o_ready=0 three cycles in HALF with hb 32-bit -> outputs stable, no hb update; release -> single transfer.
REQ-033 flush_req=1 with flush_hwofs=1 in HALF -> o_valid=0 that cycle; then 0x4501FFFF@0x300 -> o_instr=0x00004501, o_pc=0x302.
REQ-034 Straddle with i_err=1 on the first word only -> straddled instruction shows o_buserr=1; the following 16-bit instruction from the second word shows o_buserr=0.
